pipe_hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding controller for the in-order pipeline; replaces the fixed StallControl/ForwardUnit pair.

---
 rtl/pipe_hazard_scoreboard_if.sv | 34 +++
 rtl/pipe_hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_scoreboard_if.sv
// rtl/pipe_hazard_scoreboard_if.sv - ID-stage operand/issue bundle between the decode stage and the hazard scoreboard
interface pipe_hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int LAT_W = 2,
  parameter int SEL_W = 2
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_reg_write;
  logic [REG_W-1:0] id_dest;
  logic [LAT_W-1:0] id_lat;
  logic             branch_taken;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [SEL_W-1:0] fwd_sel_a;
  logic [SEL_W-1:0] fwd_sel_b;
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_dest, id_lat, branch_taken,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_dest, id_lat, branch_taken,
    output pc_we, ifid_we, ifid_flush, idex_bubble, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - in-flight writer scoreboard driving stall/bubble/flush and operand forward selects
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_scoreboard #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3,
  parameter int LAT_W = 2,
  parameter int SEL_W = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  pipe_hazard_scoreboard_if.slave hz
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             stall;
    logic [SEL_W-1:0] sel;
  } res_t;

  logic             v_q    [DEPTH];
  logic [REG_W-1:0] dest_q [DEPTH];
  logic [IDX_W-1:0] lat_q  [DEPTH];
  logic             v_d    [DEPTH];
  logic [REG_W-1:0] dest_d [DEPTH];
  logic [IDX_W-1:0] lat_d  [DEPTH];

  res_t res_a;
  res_t res_b;
  logic stall;
  logic flush;

  // Scan oldest to youngest so the lowest-index (youngest) match overrides.
  function automatic res_t resolve(input logic use_src, input logic [REG_W-1:0] src);
    res_t             r;
    logic             hit;
    logic [IDX_W-1:0] idx;
    r   = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (use_src && (src != '0) && v_q[i] && (dest_q[i] == src)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    if (hit) begin
      if (idx < lat_q[idx]) r.stall = 1'b1;
      else if (idx == IDX_W'(DEPTH - 1)) r.sel = SEL_W'(DEPTH);
      else r.sel = SEL_W'(idx) + SEL_W'(1);
    end
    return r;
  endfunction

  always_comb begin
    res_a = resolve(hz.id_use_rs, hz.id_rs);
    res_b = resolve(hz.id_use_rt, hz.id_rt);
    stall = ~reset_i & hz.id_valid & (res_a.stall | res_b.stall);
    flush = ~reset_i & hz.branch_taken & hz.id_valid & ~stall;
  end

  assign hz.pc_we       = ~stall;
  assign hz.ifid_we     = ~stall;
  assign hz.idex_bubble = stall;
  assign hz.ifid_flush  = flush;
  assign hz.fwd_sel_a   = (stall | reset_i) ? '0 : res_a.sel;
  assign hz.fwd_sel_b   = (stall | reset_i) ? '0 : res_b.sel;

  always_comb begin
    v_d[0]    = hz.id_valid & ~stall & hz.id_reg_write & (hz.id_dest != '0);
    dest_d[0] = hz.id_dest;
    lat_d[0]  = (32'(hz.id_lat) >= 32'(DEPTH - 1)) ? IDX_W'(DEPTH - 1) : IDX_W'(hz.id_lat);
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]    = v_q[i-1];
      dest_d[i] = dest_q[i-1];
      lat_d[i]  = lat_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) v_q[i] <= 1'b0;
    end else begin
      v_q    <= v_d;
      dest_q <= dest_d;
      lat_q  <= lat_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed scoreboard bench for pipe_hazard_scoreboard (DEPTH=3)
module tb_pipe_hazard_scoreboard;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  typedef struct {
    string      tag;
    logic       pc_we;
    logic       ifid_we;
    logic       flush;
    logic       bubble;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
  } exp_t;

  exp_t sb_q[$];

  pipe_hazard_scoreboard_if #(.REG_W(5), .LAT_W(2), .SEL_W(2)) hz ();

  pipe_hazard_scoreboard #(.REG_W(5), .DEPTH(3), .LAT_W(2), .SEL_W(2)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw,
                       input logic [4:0] dest, input logic [1:0] lat, input logic br);
    hz.id_valid     = v;
    hz.id_rs        = rs;
    hz.id_rt        = rt;
    hz.id_use_rs    = urs;
    hz.id_use_rt    = urt;
    hz.id_reg_write = rw;
    hz.id_dest      = dest;
    hz.id_lat       = lat;
    hz.branch_taken = br;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
  endtask

  // Push the expected response for the inputs now driven, then pop and compare mid-cycle.
  task automatic cycle(input string tag, input logic stall, input logic flush,
                       input logic [1:0] sa, input logic [1:0] sb);
    exp_t e;
    exp_t g;
    e.tag = tag; e.pc_we = ~stall; e.ifid_we = ~stall; e.bubble = stall;
    e.flush = flush; e.sel_a = sa; e.sel_b = sb;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check({g.tag, ".pc_we"},       32'(hz.pc_we),       32'(g.pc_we));
      check({g.tag, ".ifid_we"},     32'(hz.ifid_we),     32'(g.ifid_we));
      check({g.tag, ".ifid_flush"},  32'(hz.ifid_flush),  32'(g.flush));
      check({g.tag, ".idex_bubble"}, 32'(hz.idex_bubble), 32'(g.bubble));
      check({g.tag, ".fwd_sel_a"},   32'(hz.fwd_sel_a),   32'(g.sel_a));
      check({g.tag, ".fwd_sel_b"},   32'(hz.fwd_sel_b),   32'(g.sel_b));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      idle();
      cycle("drain", 1'b0, 1'b0, 2'd0, 2'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    cycle("reset0", 1'b0, 1'b0, 2'd0, 2'd0);
    cycle("reset1", 1'b0, 1'b0, 2'd0, 2'd0);
    reset = 1'b0;
    check("reset.stall_cnt", hz.stall_cnt, 32'd0);
    check("reset.flush_cnt", hz.flush_cnt, 32'd0);
    cycle("idle", 1'b0, 1'b0, 2'd0, 2'd0);

    // ALU back-to-back: forward from EX
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 2'd0, 1'b0);
    cycle("t1_add", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 2'd0, 1'b0);
    cycle("t1_sub", 1'b0, 1'b0, 2'd1, 2'd0);
    drain();

    // load-use: one stall then forward from MEM
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 2'd1, 1'b0);
    cycle("t2_lw", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 2'd0, 1'b0);
    cycle("t2_stall", 1'b1, 1'b0, 2'd0, 2'd0);
    cycle("t2_fwd", 1'b0, 1'b0, 2'd2, 2'd2);
    drain();

    // WB bypass two cycles later, r0 never forwarded
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 2'd0, 1'b0);
    cycle("t3_add", 1'b0, 1'b0, 2'd0, 2'd0);
    idle();
    cycle("t3_nop0", 1'b0, 1'b0, 2'd0, 2'd0);
    cycle("t3_nop1", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 2'd0, 1'b0);
    cycle("t3_or", 1'b0, 1'b0, 2'd3, 2'd0);
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 2'd0, 1'b0);
    cycle("t3_addi_r0", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 2'd0, 1'b0);
    cycle("t3_r0_reader", 1'b0, 1'b0, 2'd0, 2'd0);
    drain();

    // youngest producer wins
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 2'd0, 1'b0);
    cycle("t4_add_a", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 1'b0);
    cycle("t4_add_b", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd7, 2'd0, 1'b0);
    cycle("t4_sub", 1'b1, 1'b0, 2'd0, 2'd0);
    cycle("t4_sub_go", 1'b0, 1'b0, 2'd2, 2'd0);
    drain();

    // branch on load result: flush held off until the stall clears
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 2'd1, 1'b0);
    cycle("t5_lw", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b1);
    cycle("t5_beq_stall", 1'b1, 1'b0, 2'd0, 2'd0);
    cycle("t5_beq_go", 1'b0, 1'b1, 2'd2, 2'd0);
    drain();

    // latency clamp: lat=3 behaves as lat=2, then an unused-source reader
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 2'd3, 1'b0);
    cycle("t6_long", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 2'd0, 1'b0);
    cycle("t6_stall0", 1'b1, 1'b0, 2'd0, 2'd0);
    cycle("t6_stall1", 1'b1, 1'b0, 2'd0, 2'd0);
    cycle("t6_wb", 1'b0, 1'b0, 2'd3, 2'd0);
    drive(1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    cycle("t6_unused", 1'b0, 1'b0, 2'd0, 2'd0);
    drain();

    // reset with three live entries drops them all
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 2'd0, 1'b0);
    cycle("t7_p3", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 2'd0, 1'b0);
    cycle("t7_p4", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 2'd0, 1'b0);
    cycle("t7_p5", 1'b0, 1'b0, 2'd0, 2'd0);
    reset = 1'b1;
    idle();
    cycle("t7_reset", 1'b0, 1'b0, 2'd0, 2'd0);
    reset = 1'b0;
    drive(1'b1, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
    cycle("t7_after", 1'b0, 1'b0, 2'd0, 2'd0);
    check("t7.stall_cnt", hz.stall_cnt, 32'd0);
    check("t7.flush_cnt", hz.flush_cnt, 32'd0);

    // counter run: two stalls, one flush
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 2'd1, 1'b0);
    cycle("t8_lw3", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b1);
    cycle("t8_beq_stall", 1'b1, 1'b0, 2'd0, 2'd0);
    cycle("t8_beq_go", 1'b0, 1'b1, 2'd2, 2'd0);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 2'd1, 1'b0);
    cycle("t8_lw4", 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 2'd0, 1'b0);
    cycle("t8_add_stall", 1'b1, 1'b0, 2'd0, 2'd0);
    cycle("t8_add_go", 1'b0, 1'b0, 2'd2, 2'd0);
    idle();
    cycle("t8_idle", 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZ_PERF_CNT_EN
    check("t8.stall_cnt", hz.stall_cnt, 32'd2);
    check("t8.flush_cnt", hz.flush_cnt, 32'd1);
`else
    check("t8.stall_cnt", hz.stall_cnt, 32'd0);
    check("t8.flush_cnt", hz.flush_cnt, 32'd0);
`endif
    check("scoreboard.empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
